mac_scheduler: RTL
==================

Name: mac_scheduler

Overview:
- Sequences the 8-row matrix-vector MAC array once the fetch controller has filled the A FIFOs (one per row) and the B FIFO.
- Issues staggered (systolic) FIFO reads and MAC enables so that B values propagate row to row through the array.
- After the last MAC update, streams the row accumulators out one per cycle under a valid/ready handshake.
- Uses the same start/done handshake as the fetch controller.

Parameters:
ROWS, 8, number of A rows / MAC units
COLS, 8, vector length (bytes per row)
ACC_W, 24, accumulator width per MAC

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a compute pass (level; sampled in IDLE)
done  out  1  pass complete; held until start deasserts
busy  out  1  high in every state except IDLE and DONE
a_fifo_empty  in  ROWS  per-row A FIFO empty
a_fifo_rden  out  ROWS  per-row A FIFO read enable (1-cycle read latency)
b_fifo_empty  in  1  B FIFO empty
b_fifo_rden  out  1  B FIFO read enable (1-cycle read latency)
mac_clr  out  1  clears all accumulators and the B shift chain
mac_en  out  ROWS  per-row MAC update enable; also advances that row's B stage
mac_acc  in  ROWS*ACC_W  packed accumulators; row r at [r*ACC_W +: ACC_W]
res_valid  out  1  result beat valid
res_ready  in  1  downstream accepts beat
res_idx  out  3  row index of the current beat
res_data  out  ACC_W  accumulator of row res_idx

Behaviour:
- Reset: synchronous, checked only at the clk edge while rst_n=0. On reset: state=IDLE; k=0; out_idx=0; mac_en pipeline cleared. Every output is 0 (done, busy, a_fifo_rden, b_fifo_rden, mac_clr, mac_en, res_valid, res_idx, res_data).
- Reset mid-pass aborts the pass. No rden or mac_en is asserted on the cycle after reset.
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- IDLE: if start=1, go to CLEAR. No other outputs are asserted.
- CLEAR: mac_clr=1 for exactly 1 cycle; k cleared to 0; next state FEED.
- FEED: k runs 0..COLS+ROWS-2, which is 15 cycles with no stalls.
  - Requested b_fifo_rden = (k < COLS).
  - Requested a_fifo_rden[r] = (r <= k < r+COLS).
- FEED stall rule: if any requested read targets an empty FIFO, force all rden to 0 and hold k (a global stall). Otherwise drive the requested reads and increment k.
- FEED exit: when a non-stalled issue occurs with k = COLS+ROWS-2, go to DRAIN.
- mac_en[r] is a_fifo_rden[r] registered by one cycle, to match FIFO read latency. Each row therefore gets exactly COLS rden pulses and COLS mac_en pulses per pass. The B FIFO gets exactly COLS rden pulses.
- DRAIN: 1 cycle, during which the final mac_en[ROWS-1] pulse occurs; next state OUTPUT with out_idx=0.
- OUTPUT: res_valid=1; res_idx=out_idx; res_data = mac_acc slice for out_idx (combinational from mac_acc).
  - On res_valid & res_ready: out_idx increments. If out_idx = ROWS-1, go to DONE.
  - While res_ready=0: hold res_idx and res_data stable; do not skip beats.
- DONE: done=1. If start=0, go to IDLE; otherwise stay in DONE. A new pass therefore needs start to be deasserted and then reasserted.
- start is ignored in every state except IDLE and DONE.
- FIFO empties are ignored outside FEED. The FIFOs are never read outside FEED.
- Width rules: ACC_W must be at least 16+log2(COLS) to avoid overflow. The scheduler does no arithmetic on data.
- k width is clog2(COLS+ROWS). It must not wrap during FEED.
- Nominal timing, with start sampled at cycle 0 and no stalls or backpressure:
  - CLEAR at cycle 1.
  - FEED at cycles 2-16.
  - DRAIN at cycle 17.
  - Result beats at cycles 18-25.
  - done first high at cycle 26.

Test Plan:
- Nominal run: A row r preloaded with eight bytes of value r+1, B preloaded 1..8, res_ready=1.
  - Required: one mac_clr pulse at cycle 1.
  - Required: a_fifo_rden[r] first asserted at cycle 2+r for 8 cycles.
  - Required: results at res_idx 0..7 equal (r+1)*36, i.e. 36, 72, ..., 288, at cycles 18-25.
  - Required: done at cycle 26.
- Stall: hold b_fifo_empty=1 for 3 cycles when k=2.
  - Required: all rden and k frozen for those 3 cycles.
  - Required: results identical to the nominal run; done at cycle 29.
- Backpressure: res_ready=0 for 2 cycles while res_idx=3.
  - Required: res_idx=3 and res_data=144 held for those cycles; all 8 beats still delivered in order; done 2 cycles late.
- Handshake: keep start high after done.
  - Required: stays in DONE.
  - Then drop start and reassert it with new data: IDLE, then a second mac_clr pulse; results reflect the new data only.
- Reset mid-FEED: rst_n=0 at k=5.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: after release, no rden until start is reasserted.
- start toggled during FEED and OUTPUT.
  - Required: no effect; rden/mac_en pulse counts stay at 8 per row.

Source files
------------

// File: rtl/mac_scheduler.sv
// mac_scheduler: sequences systolic FIFO reads and MAC enables for the row array, then streams the accumulators out.
module mac_scheduler #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic [ROWS-1:0]       a_fifo_empty,
  output logic [ROWS-1:0]       a_fifo_rden,
  input  logic                  b_fifo_empty,
  output logic                  b_fifo_rden,
  output logic                  mac_clr,
  output logic [ROWS-1:0]       mac_en,
  input  logic [ROWS*ACC_W-1:0] mac_acc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2:0]            res_idx,
  output logic [ACC_W-1:0]      res_data
);
  localparam int KW   = $clog2(COLS + ROWS);
  localparam int KMAX = COLS + ROWS - 2;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE} state_t;
  state_t          state;
  logic [KW-1:0]   k;
  logic [2:0]      out_idx;
  logic [ROWS-1:0] a_req;
  logic            b_req, stall, issue;
  // Row r consumes column k-r, so B values reach each row one cycle after the row above.
  always_comb begin
    b_req = int'(k) < COLS;
    for (int r = 0; r < ROWS; r++) a_req[r] = (int'(k) >= r) && (int'(k) < r + COLS);
    stall = (b_req && b_fifo_empty) || |(a_req & a_fifo_empty);
  end
  assign issue       = (state == FEED) && !stall;
  assign a_fifo_rden = issue ? a_req : '0;
  assign b_fifo_rden = issue && b_req;
  assign mac_clr     = state == CLEAR;
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = state == DONE;
  assign res_valid   = state == OUTPUT;
  assign res_idx     = out_idx;
  assign res_data    = res_valid ? mac_acc[int'(out_idx)*ACC_W +: ACC_W] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      out_idx <= '0;
      mac_en  <= '0;
    end else begin
      mac_en <= a_fifo_rden;
      case (state)
        IDLE:    if (start) state <= CLEAR;
        CLEAR: begin
          k     <= '0;
          state <= FEED;
        end
        FEED: if (!stall) begin
          k <= k + 1'b1;
          if (int'(k) == KMAX) state <= DRAIN;
        end
        DRAIN: begin
          out_idx <= '0;
          state   <= OUTPUT;
        end
        OUTPUT: if (res_ready) begin
          out_idx <= out_idx + 1'b1;
          if (out_idx == 3'(ROWS - 1)) state <= DONE;
        end
        DONE:    if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
